psum_deskew_writer: RTL and testbench

Output stage of the 8x8 systolic array. Takes column-skewed partial sums from the array bottom edge, realigns them into whole result rows, and writes one row per cycle into the result SRAM. Signals job completion to the top-level controller, which drives `end_`.

---
 rtl/psum_deskew_writer_if.sv | 30 +++
 rtl/psum_deskew_writer.sv | 135 +++++++++++++
 tb/tb_psum_deskew_writer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/psum_deskew_writer_if.sv
// psum_deskew_writer_if: bus bundle between the systolic array bottom edge,
// the top-level controller and the result-SRAM write port.
// master = array/controller side (drives row data and job control),
// slave  = psum_deskew_writer (drives SRAM write strobe and job status).
interface psum_deskew_writer_if #(
   parameter int MATRIX_SIZE    = 8,
   parameter int PARTIAL_SUM_BW = 20,
   parameter int ADDRESSSIZE    = 10
);
   logic                                  start;
   logic [ADDRESSSIZE-1:0]                base_addr;
   logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] psum_in;
   logic [MATRIX_SIZE-1:0]                psum_valid_in;
   logic                                  wr_en;
   logic [ADDRESSSIZE-1:0]                wr_addr;
   logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] wr_data;
   logic                                  busy;
   logic                                  done;
   logic                                  skew_err;

   modport master (
      output start, base_addr, psum_in, psum_valid_in,
      input  wr_en, wr_addr, wr_data, busy, done, skew_err
   );

   modport slave (
      input  start, base_addr, psum_in, psum_valid_in,
      output wr_en, wr_addr, wr_data, busy, done, skew_err
   );
endinterface

// File: rtl/psum_deskew_writer.sv
// psum_deskew_writer: realigns column-skewed partial sums from the array
// bottom edge into whole rows and writes one row per cycle to the result SRAM.
// Column j lags column 0 by j cycles, so it is delayed by MATRIX_SIZE-j stages.
// Optional feature: define PSUM_RELU_EN to clamp negative fields of each
// written row to zero at the write register (latency unchanged).
module psum_deskew_writer #(
   parameter int MATRIX_SIZE    = 8,
   parameter int PARTIAL_SUM_BW = 20,
   parameter int ADDRESSSIZE    = 10
) (
   input logic                 clk,
   input logic                 rstn,
   psum_deskew_writer_if.slave bus
);
   localparam int ROW_W = MATRIX_SIZE * PARTIAL_SUM_BW;
   localparam int CNT_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FINAL, S_DONE} state_t;

   logic [MATRIX_SIZE-1:0] w_vld_dly;
   logic [ROW_W-1:0]       w_row_dly;
   logic                   w_aligned;
   logic                   w_misaligned;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_row_cnt;
   logic [ADDRESSSIZE-1:0] r_next_addr;
   logic [ADDRESSSIZE-1:0] r_wr_addr;
   logic [ROW_W-1:0]       r_wr_data;
   logic                   r_wr_en;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_skew_err;

   // Row post-processing applied as the row is captured into the write register.
   function automatic logic [ROW_W-1:0] f_relu(input logic [ROW_W-1:0] row);
      logic [ROW_W-1:0] res;
      res = row;
`ifdef PSUM_RELU_EN
      for (int j = 0; j < MATRIX_SIZE; j++) begin
         if (row[j*PARTIAL_SUM_BW + PARTIAL_SUM_BW - 1])
            res[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = '0;
      end
`endif
      return res;
   endfunction

   generate
      for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
         localparam int DEPTH = MATRIX_SIZE - j;
         logic signed [PARTIAL_SUM_BW-1:0] r_data_p [DEPTH];
         logic [DEPTH-1:0]                 r_vld_p;

         // Deskew shift register for column j; data and valid move together every cycle.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int k = 0; k < DEPTH; k++) r_data_p[k] <= '0;
               r_vld_p <= '0;
            end else begin
               r_data_p[0] <= bus.psum_in[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
               r_vld_p[0]  <= bus.psum_valid_in[j];
               for (int k = 1; k < DEPTH; k++) begin
                  r_data_p[k] <= r_data_p[k-1];
                  r_vld_p[k]  <= r_vld_p[k-1];
               end
            end
         end

         assign w_row_dly[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = r_data_p[DEPTH-1];
         assign w_vld_dly[j] = r_vld_p[DEPTH-1];
      end
   endgenerate

   // Row alignment: a row is whole only when every delayed column is valid together.
   assign w_aligned    = &w_vld_dly;
   assign w_misaligned = (|w_vld_dly) & ~w_aligned;

   // Job FSM with registered SRAM write port and status outputs.
   // S_FINAL is the cycle the last write is on the port; S_DONE holds done for one cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_row_cnt   <= '0;
         r_next_addr <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_en     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_skew_err  <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         if (w_misaligned) r_skew_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state     <= S_COLLECT;
                  r_row_cnt   <= '0;
                  r_wr_addr   <= bus.base_addr;
                  r_next_addr <= bus.base_addr;
                  r_skew_err  <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (w_aligned) begin
                  r_wr_en     <= 1'b1;
                  r_wr_data   <= f_relu(w_row_dly);
                  r_wr_addr   <= r_next_addr;
                  r_next_addr <= r_next_addr + 1'b1;
                  r_row_cnt   <= r_row_cnt + 1'b1;
                  if (r_row_cnt == CNT_W'(MATRIX_SIZE - 1)) r_state <= S_FINAL;
               end
            end
            S_FINAL: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.wr_en    = r_wr_en;
   assign bus.wr_addr  = r_wr_addr;
   assign bus.wr_data  = r_wr_data;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.skew_err = r_skew_err;
endmodule

// File: tb/tb_psum_deskew_writer.sv
// tb_psum_deskew_writer: directed, table-driven bench for psum_deskew_writer.
// Jobs are described by a table of {base address, negative-element flag,
// expected column-3 value}; corner cases are hand-written sequences.
module tb_psum_deskew_writer;
   localparam int MS = 8;
   localparam int W  = 20;
   localparam int AW = 10;

`ifdef PSUM_RELU_EN
   localparam logic [W-1:0] C3_NEG_EXP = 20'h00000;
`else
   localparam logic [W-1:0] C3_NEG_EXP = 20'hFFFF6;
`endif

   typedef struct {
      logic [AW-1:0] base;
      logic          neg;
      logic [W-1:0]  exp_c3;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   e0;

   logic [AW-1:0]   wa[$];
   logic [MS*W-1:0] wd[$];
   int              wc[$];
   logic            wb[$];
   int              dq[$];
   logic            db[$];

   vec_t vecs[4];

   psum_deskew_writer_if #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(W), .ADDRESSSIZE(AW)) bus ();

   psum_deskew_writer #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(W), .ADDRESSSIZE(AW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write/done monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.wr_en) begin
         wa.push_back(bus.wr_addr);
         wd.push_back(bus.wr_data);
         wc.push_back(cyc);
         wb.push_back(bus.busy);
      end
      if (bus.done) begin
         dq.push_back(cyc);
         db.push_back(bus.busy);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clr_q();
      wa.delete(); wd.delete(); wc.delete(); wb.delete(); dq.delete(); db.delete();
   endtask

   function automatic logic [W-1:0] in_val(input int r, input int j, input logic neg);
      if (neg && r == 0 && j == 3) return 20'hFFFF6;
      return W'(16 * r + j);
   endfunction

   function automatic logic [W-1:0] exp_val(input int r, input int j, input logic neg,
                                             input logic [W-1:0] exp_c3);
      if (neg && r == 0 && j == 3) return exp_c3;
      return W'(16 * r + j);
   endfunction

   // Drive nrows skewed rows; drop_row loses its column-5 element (valid slips
   // into the next row's slot). Optional extra start pulse at cycle restart_t.
   task automatic drive_job(input logic do_start, input logic [AW-1:0] base, input int nrows,
                            input logic neg, input int drop_row, input int restart_t,
                            output int e_first);
      logic [MS*W-1:0] d;
      logic [MS-1:0]   v;
      @(negedge clk);
      e_first = cyc + 1;
      for (int t = 0; t < nrows + MS; t++) begin
         for (int j = 0; j < MS; j++) begin
            int r;
            r = t - j;
            v[j] = (r >= 0) && (r < nrows) && !(r == drop_row && j == 5);
            d[j*W +: W] = v[j] ? in_val(r, j, neg) : '0;
         end
         bus.start         = (do_start && t == 0) || (t == restart_t);
         bus.base_addr     = (t == 0) ? base : 10'd500;
         bus.psum_in       = d;
         bus.psum_valid_in = v;
         @(negedge clk);
      end
      bus.start         = 1'b0;
      bus.psum_in       = '0;
      bus.psum_valid_in = '0;
   endtask

   task automatic check_job(input string tag, input logic [AW-1:0] base, input int nrows,
                            input logic neg, input logic [W-1:0] exp_c3, input int drop_row,
                            input int e_first, input logic exp_skew);
      int rows[$];
      int n;
      for (int r = 0; r < nrows && rows.size() < MS; r++)
         if (r != drop_row) rows.push_back(r);
      chk({tag, " wr_count"}, 64'(wa.size()), 64'(MS));
      n = (wa.size() < MS) ? wa.size() : MS;
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s wr_addr[%0d]", tag, k), 64'(wa[k]), 64'((int'(base) + k) % 1024));
         chk($sformatf("%s wr_cycle[%0d]", tag, k), 64'(wc[k]), 64'(e_first + MS + rows[k]));
         chk($sformatf("%s busy_at_wr[%0d]", tag, k), 64'(wb[k]), 64'(1));
         for (int j = 0; j < MS; j++)
            chk($sformatf("%s wr_data[%0d][%0d]", tag, k, j), 64'(wd[k][j*W +: W]),
                64'(exp_val(rows[k], j, neg, exp_c3)));
      end
      chk({tag, " done_count"}, 64'(dq.size()), 64'(1));
      if (dq.size() > 0 && wc.size() > 0) begin
         chk({tag, " done_cycle"}, 64'(dq[0]), 64'(wc[wc.size()-1] + 1));
         chk({tag, " busy_at_done"}, 64'(db[0]), 64'(0));
      end
      chk({tag, " skew_err"}, 64'(bus.skew_err), 64'(exp_skew));
   endtask

   initial begin
      vecs[0] = '{base: 10'd32,   neg: 1'b0, exp_c3: 20'd0};
      vecs[1] = '{base: 10'd0,    neg: 1'b0, exp_c3: 20'd0};
      vecs[2] = '{base: 10'd1020, neg: 1'b0, exp_c3: 20'd0};
      vecs[3] = '{base: 10'd5,    neg: 1'b1, exp_c3: C3_NEG_EXP};

      bus.start = 1'b0; bus.base_addr = '0; bus.psum_in = '0; bus.psum_valid_in = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst wr_en",    64'(bus.wr_en),    64'(0));
      chk("rst wr_addr",  64'(bus.wr_addr),  64'(0));
      chk("rst wr_data",  64'(bus.wr_data[63:0]), 64'(0));
      chk("rst busy",     64'(bus.busy),     64'(0));
      chk("rst done",     64'(bus.done),     64'(0));
      chk("rst skew_err", 64'(bus.skew_err), 64'(0));
      rstn = 1'b1;

      // Aligned rows while IDLE are discarded silently
      clr_q();
      drive_job(1'b0, 10'd0, MS, 1'b0, -1, -1, e0);
      repeat (6) @(negedge clk);
      chk("idle wr_count", 64'(wa.size()), 64'(0));
      chk("idle done",     64'(dq.size()), 64'(0));
      chk("idle skew_err", 64'(bus.skew_err), 64'(0));
      chk("idle busy",     64'(bus.busy), 64'(0));

      // Reset mid-job after three writes
      clr_q();
      fork
         drive_job(1'b1, 10'd100, MS, 1'b0, -1, -1, e0);
         begin
            for (int i = 0; i < 40 && wa.size() < 3; i++) begin
               @(posedge clk);
               #2;
            end
            chk("midrst writes_before", 64'(wa.size()), 64'(3));
            rstn = 1'b0;
            #1;
            chk("midrst wr_en",   64'(bus.wr_en),   64'(0));
            chk("midrst busy",    64'(bus.busy),    64'(0));
            chk("midrst wr_addr", 64'(bus.wr_addr), 64'(0));
            repeat (2) @(negedge clk);
            rstn = 1'b1;
         end
      join
      repeat (12) @(negedge clk);
      chk("midrst writes_after", 64'(wa.size()), 64'(3));
      chk("midrst done",         64'(dq.size()), 64'(0));

      // Table-driven nominal jobs: fresh job at 32, base 0, wrap at 1020, negative element
      for (int i = 0; i < 4; i++) begin
         clr_q();
         drive_job(1'b1, vecs[i].base, MS, vecs[i].neg, -1, -1, e0);
         repeat (4) @(negedge clk);
         check_job($sformatf("vec%0d", i), vecs[i].base, MS, vecs[i].neg, vecs[i].exp_c3,
                   -1, e0, 1'b0);
      end

      // Misalignment: row 2 loses column 5 alignment; a 9th row completes the job
      clr_q();
      drive_job(1'b1, 10'd0, MS + 1, 1'b0, 2, -1, e0);
      repeat (4) @(negedge clk);
      check_job("skew", 10'd0, MS + 1, 1'b0, 20'd0, 2, e0, 1'b1);

      // start during COLLECT is ignored
      clr_q();
      drive_job(1'b1, 10'd200, MS, 1'b0, -1, 10, e0);
      repeat (4) @(negedge clk);
      check_job("restart", 10'd200, MS, 1'b0, 20'd0, -1, e0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
